// File: rtl/noc_pkt_defs.sv
// Shared fabric packet definitions: flit type codes, header field map and address geometry.
// Optional INJ_HDR_PARITY_EN places even parity of header bits [24:0] in header bit 31.
package noc_pkt_defs;

    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned LEAF_W     = 2;
    localparam int unsigned LEN_W      = 5;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned HDR_W      = 32;
    localparam int unsigned NUM_GROUPS = 8;

    localparam int unsigned DEST_LSB = 0;
    localparam int unsigned SRC_LSB  = 6;
    localparam int unsigned LEN_LSB  = 12;
    localparam int unsigned SEQ_LSB  = 17;
    localparam int unsigned PAR_BIT  = 31;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10
    } inj_state_e;

    // Assemble a head-flit header; unused upper bits stay zero.
    function automatic logic [HDR_W-1:0] build_hdr(
        input logic [ADDR_W-1:0] dest,
        input logic [ADDR_W-1:0] src,
        input logic [LEN_W-1:0]  len,
        input logic [SEQ_W-1:0]  seq
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[DEST_LSB +: ADDR_W] = dest;
        h[SRC_LSB  +: ADDR_W] = src;
        h[LEN_LSB  +: LEN_W]  = len;
        h[SEQ_LSB  +: SEQ_W]  = seq;
`ifdef INJ_HDR_PARITY_EN
        h[PAR_BIT] = ^h[SEQ_LSB+SEQ_W-1:0];
`else
        h[PAR_BIT] = 1'b0;
`endif
        return h;
    endfunction

endpackage

// File: rtl/noc_dest_check.sv
// Combinational request legality check: destination group range, self-loop and length bounds.
module noc_dest_check
    import noc_pkt_defs::*;
#(
    parameter logic [GROUP_W-1:0] GROUP_ID  = 4'b0011,
    parameter logic [LEAF_W-1:0]  LEAF_ID   = 2'b00,
    parameter int unsigned        MAX_BEATS = 16
) (
    input  logic [ADDR_W-1:0] dest_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              valid_c
);

    logic [GROUP_W-1:0] group;
    logic               len_ok;
    logic               group_ok;
    logic               not_self;

    always_comb begin
        group    = dest_i[ADDR_W-1:LEAF_W];
        len_ok   = (len_i != '0) && (len_i <= LEN_W'(MAX_BEATS));
        group_ok = (group != '0) && (group <= GROUP_W'(NUM_GROUPS));
        not_self = (dest_i != {GROUP_ID, LEAF_ID});
        valid_c  = len_ok && group_ok && not_self;
    end

endmodule

// File: rtl/leaf_pkt_injector.sv
// Leaf uplink injector: validates requests, frames head/body/tail flits, stamps source and sequence.
// Header parity in bit 31 is enabled by defining INJ_HDR_PARITY_EN.
module leaf_pkt_injector
    import noc_pkt_defs::*;
#(
    parameter logic [GROUP_W-1:0] GROUP_ID  = 4'b0011,
    parameter logic [LEAF_W-1:0]  LEAF_ID   = 2'b00,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              beat_valid,
    output logic              beat_ready,
    input  logic [DATA_W-1:0] beat_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [1:0]        flit_type,
    output logic [DATA_W-1:0] flit_data,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  pkt_cnt
);

    inj_state_e         state_q, state_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [LEN_W-1:0]   beats_left_q, beats_left_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic               err_q, err_d;
    logic               req_ready_q;
    logic               req_ok_c;

    noc_dest_check #(
        .GROUP_ID  (GROUP_ID),
        .LEAF_ID   (LEAF_ID),
        .MAX_BEATS (MAX_BEATS)
    ) u_dest_check (
        .dest_i  (req_dest),
        .len_i   (req_len),
        .valid_c (req_ok_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            beats_left_q <= '0;
            seq_q        <= '0;
            pkt_cnt_q    <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            beats_left_q <= beats_left_d;
            seq_q        <= seq_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_q        <= err_d;
            // Registered so the uplink handshake never reaches req_ready combinationally.
            req_ready_q  <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        beats_left_d = beats_left_q;
        seq_d        = seq_q;
        pkt_cnt_d    = pkt_cnt_q;
        err_d        = 1'b0;
        flit_valid   = 1'b0;
        flit_type    = FLIT_BODY;
        flit_data    = '0;
        beat_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_ok_c) begin
                        hdr_d   = build_hdr(req_dest, {GROUP_ID, LEAF_ID}, req_len, seq_q);
                        state_d = ST_HEAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEAD: begin
                flit_valid = 1'b1;
                flit_type  = FLIT_HEAD;
                flit_data  = DATA_W'(hdr_q);
                if (flit_ready) begin
                    beats_left_d = hdr_q[LEN_LSB +: LEN_W];
                    state_d      = ST_BODY;
                end
            end
            ST_BODY: begin
                // Zero-latency pass-through of payload beats to the uplink.
                flit_valid = beat_valid;
                beat_ready = flit_ready;
                flit_data  = beat_data;
                flit_type  = (beats_left_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                if (beat_valid && flit_ready) begin
                    beats_left_d = beats_left_q - LEN_W'(1);
                    if (beats_left_q == LEN_W'(1)) begin
                        seq_d     = seq_q + SEQ_W'(1);
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = req_ready_q;
    assign err_pulse = err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_leaf_pkt_injector.sv
// Directed, table-driven bench for leaf_pkt_injector plus reset-abort and sequence-wrap sequences.
module tb_leaf_pkt_injector;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_dest;
    logic [4:0]        req_len;
    logic              beat_valid;
    logic              beat_ready;
    logic [DATA_W-1:0] beat_data;
    logic              flit_valid;
    logic              flit_ready;
    logic [1:0]        flit_type;
    logic [DATA_W-1:0] flit_data;
    logic              err_pulse;
    logic [15:0]       pkt_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  dest;
        logic [4:0]  len;
        bit          err;
        logic [31:0] hdr;
        bit          toggle;
    } vec_t;

    vec_t        vecs[10];
    logic [7:0]  seq_m;
    logic [15:0] cnt_m;

    leaf_pkt_injector #(
        .GROUP_ID  (4'b0011),
        .LEAF_ID   (2'b00),
        .DATA_W    (DATA_W),
        .MAX_BEATS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_data  (beat_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_type  (flit_type),
        .flit_data  (flit_data),
        .err_pulse  (err_pulse),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] add_par(input logic [31:0] h);
        logic [31:0] r;
        r = h;
`ifdef INJ_HDR_PARITY_EN
        r[31] = ^h[24:0];
`endif
        return r;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [5:0] dest, input logic [4:0] len,
                                           input logic [7:0] seq);
        return 32'(dest) | (32'd12 << 6) | (32'(len) << 12) | (32'(seq) << 17);
    endfunction

    // Called at a falling edge; returns at a falling edge.
    task automatic run_req(input logic [5:0] dest, input logic [4:0] len, input bit exp_err,
                           input logic [31:0] hdr, input bit toggle, input int abort_at,
                           input logic [15:0] cnt_before);
        int idx;
        int cyc;
        logic [31:0] exp_hdr;
        logic [1:0]  exp_t;
        logic [31:0] exp_d;
        exp_hdr = add_par(hdr);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_dest  = dest;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_err) begin
            chk("err_pulse_hi", 32'(err_pulse), 32'd1);
            chk("err_no_flit", 32'(flit_valid), 32'd0);
            chk("err_pkt_cnt", 32'(pkt_cnt), 32'(cnt_before));
            @(negedge clk);
            chk("err_pulse_lo", 32'(err_pulse), 32'd0);
            chk("err_no_flit2", 32'(flit_valid), 32'd0);
            return;
        end
        chk("ok_no_err", 32'(err_pulse), 32'd0);
        idx = 0;
        cyc = 0;
        while (idx <= int'(len) && cyc < 200) begin
            if (abort_at == idx) begin
                rst_n = 1'b0;
                beat_valid = 1'b0;
                #1;
                chk("abort_flit_valid", 32'(flit_valid), 32'd0);
                chk("abort_req_ready", 32'(req_ready), 32'd0);
                chk("abort_beat_ready", 32'(beat_ready), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_pkt_cnt", 32'(pkt_cnt), 32'd0);
                chk("abort_req_ready_up", 32'(req_ready), 32'd1);
                chk("abort_idle_flit", 32'(flit_valid), 32'd0);
                return;
            end
            flit_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            beat_valid = (idx > 0);
            beat_data  = 32'hA0 + 32'(idx);
            #1;
            exp_t = (idx == 0) ? 2'b01 : ((idx == int'(len)) ? 2'b10 : 2'b00);
            exp_d = (idx == 0) ? exp_hdr : 32'hA0 + 32'(idx);
            chk("flit_valid", 32'(flit_valid), 32'd1);
            chk("flit_type", 32'(flit_type), 32'(exp_t));
            chk("flit_data", flit_data, exp_d);
            chk("beat_ready", 32'(beat_ready), (idx > 0) ? 32'(flit_ready) : 32'd0);
            @(posedge clk);
            if (flit_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) chk("stream_timeout", 32'd0, 32'd1);
        beat_valid = 1'b0;
        flit_ready = 1'b0;
        #1;
        chk("bubble_flit_valid", 32'(flit_valid), 32'd0);
        chk("bubble_req_ready", 32'(req_ready), 32'd1);
        chk("pkt_cnt", 32'(pkt_cnt), 32'(cnt_before + 16'd1));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_dest = '0; req_len = '0;
        beat_valid = 1'b0; beat_data = '0; flit_ready = 1'b0;

        vecs[0] = '{6'b0101_10, 5'd3,  1'b0, 32'h0000_3316, 1'b0};
        vecs[1] = '{6'b0001_00, 5'd1,  1'b0, 32'h0002_1304, 1'b0};
        vecs[2] = '{6'b0011_00, 5'd2,  1'b1, 32'h0,         1'b0};
        vecs[3] = '{6'b0000_01, 5'd2,  1'b1, 32'h0,         1'b0};
        vecs[4] = '{6'b1001_00, 5'd2,  1'b1, 32'h0,         1'b0};
        vecs[5] = '{6'b0100_00, 5'd0,  1'b1, 32'h0,         1'b0};
        vecs[6] = '{6'b0100_00, 5'd17, 1'b1, 32'h0,         1'b0};
        vecs[7] = '{6'b1000_00, 5'd16, 1'b0, 32'h0005_0320, 1'b0};
        vecs[8] = '{6'b0011_01, 5'd2,  1'b0, 32'h0006_230D, 1'b1};
        vecs[9] = '{6'b0101_10, 5'd4,  1'b0, 32'h0008_4316, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_flit_valid", 32'(flit_valid), 32'd0);
        chk("rst_beat_ready", 32'(beat_ready), 32'd0);
        chk("rst_flit_type", 32'(flit_type), 32'd0);
        chk("rst_flit_data", flit_data, 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_idle_ready", 32'(req_ready), 32'd1);

        cnt_m = '0;
        seq_m = '0;
        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].dest, vecs[i].len, vecs[i].err, vecs[i].hdr, vecs[i].toggle, -1, cnt_m);
            if (!vecs[i].err) begin
                cnt_m++;
                seq_m++;
            end
        end

        // Reset after head plus two body transfers of a len=5 packet (seq 5).
        run_req(6'b0101_10, 5'd5, 1'b0, 32'h000A_5316, 1'b0, 3, cnt_m);
        cnt_m = '0;
        seq_m = '0;
        run_req(6'b0101_10, 5'd2, 1'b0, 32'h0000_2316, 1'b0, -1, cnt_m);
        cnt_m++;
        seq_m++;

        // Sequence number wraps through 255 -> 0.
        for (int p = 0; p < 256; p++) begin
            run_req(6'b0001_00, 5'd1, 1'b0, mk_hdr(6'b0001_00, 5'd1, seq_m), 1'b0, -1, cnt_m);
            cnt_m++;
            seq_m++;
        end
        chk("final_pkt_cnt", 32'(pkt_cnt), 32'd257);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
